control_unit: RTL

Hardwired control sequencer for the ELEC374 CPU, sitting directly upstream of `datapath`. It steps a Moore state machine through the fetch (T0–T2) and execute (T3–T7) cycles and drives the datapath's register-select, bus-source, load-enable, memory and ALU control lines. It decodes the instruction held in the datapath IR and waits on a memory-ready handshake for every read and write.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/ir_decode.sv | 56 +++++
 rtl/control_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, IR field positions, sequencer states and
// instruction classes. Used by control_unit, ir_decode, datapath and benches.
package cpu_pkg;

    localparam int OPW_DEF = 5;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;
    localparam int C_MSB  = 18;
    localparam int C_LSB  = 0;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_LD, CL_ST, CL_MULDIV, CL_UNARY, CL_NOP, CL_HALT, CL_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/ir_decode.sv
// Combinational opcode decode: instruction class and the ALU code the
// execute phase presents to the datapath.
module ir_decode
    import cpu_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic [OPW-1:0] op_i,
    output iclass_e        cls_o,
    output logic [4:0]     alu_o
);

    always_comb begin
        cls_o = CL_ILLEGAL;
        alu_o = '0;
        case (op_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                cls_o = CL_RTYPE;
                alu_o = 5'(op_i);
            end
            OP_ADDI: begin
                cls_o = CL_IMM;
                alu_o = OP_ADD;
            end
            OP_ANDI: begin
                cls_o = CL_IMM;
                alu_o = OP_AND;
            end
            OP_ORI: begin
                cls_o = CL_IMM;
                alu_o = OP_OR;
            end
            // Address generation for memory ops is base + C through the adder.
            OP_LD: begin
                cls_o = CL_LD;
                alu_o = OP_ADD;
            end
            OP_ST: begin
                cls_o = CL_ST;
                alu_o = OP_ADD;
            end
            OP_MUL, OP_DIV: begin
                cls_o = CL_MULDIV;
                alu_o = 5'(op_i);
            end
            OP_NEG, OP_NOT: begin
                cls_o = CL_UNARY;
                alu_o = 5'(op_i);
            end
            OP_NOP:  cls_o = CL_NOP;
            OP_HALT: cls_o = CL_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the ELEC374 CPU: fetch T0-T2, execute T3-T7,
// absorbing HALT. Outputs decode only the state register and the IR.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_control,
    output logic        run,
    output logic        illegal,
    output state_e      state_o
);

    state_e      state_q, state_d;
    iclass_e     cls;
    logic [4:0]  alu_code;
    logic        unused_ir_fields;

    // Register fields are consumed by the datapath's own decoder, not here.
    assign unused_ir_fields = ^ir[31-OPW:0];

    ir_decode #(.OPW(OPW)) u_ir_decode (
        .op_i  (ir[OP_MSB -: OPW]),
        .cls_o (cls),
        .alu_o (alu_code)
    );

    assign state_o = state_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_RST;
        else      state_q <= state_d;
    end

    // Memory handshake: Read/Write is a request held high every cycle of a
    // wait state; the rising edge that samples mem_rdy=1 completes the
    // transfer and advances the state (one cycle if mem_rdy is already high).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = mem_rdy ? S_T2 : S_T1;
            S_T2:  state_d = S_T3;
            S_T3: begin
                case (cls)
                    CL_NOP, CL_ILLEGAL: state_d = S_T0;
                    CL_HALT:            state_d = S_HALT;
                    default:            state_d = S_T4;
                endcase
            end
            S_T4:  state_d = (cls == CL_UNARY) ? S_T0 : S_T5;
            S_T5: begin
                case (cls)
                    CL_LD, CL_ST, CL_MULDIV: state_d = S_T6;
                    default:                 state_d = S_T0;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_LD:   state_d = mem_rdy ? S_T7 : S_T6;
                    CL_ST:   state_d = S_T7;
                    default: state_d = S_T0;
                endcase
            end
            S_T7: begin
                if (cls == CL_ST) state_d = mem_rdy ? S_T0 : S_T7;
                else              state_d = S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, PCout, IncPC, MARin, MDRin, MDRout, IRin} = '0;
        {Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, Read, Write, illegal} = '0;
        alu_control = '0;
        run = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: {PCout, MARin, IncPC} = '1;
            S_T1: {Read, MDRin} = '1;
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                case (cls)
                    CL_RTYPE, CL_IMM: {Grb, Rout, Yin} = '1;
                    CL_LD, CL_ST:     {Grb, BAout, Yin} = '1;
                    CL_MULDIV:        {Gra, Rout, Yin} = '1;
                    CL_UNARY: begin
                        {Grb, Rout, Zin} = '1;
                        alu_control = alu_code;
                    end
                    CL_ILLEGAL:       illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_RTYPE: begin
                        {Grc, Rout, Zin} = '1;
                        alu_control = alu_code;
                    end
                    CL_IMM, CL_LD, CL_ST: begin
                        {Cout, Zin} = '1;
                        alu_control = alu_code;
                    end
                    CL_MULDIV: begin
                        {Grb, Rout, Zin} = '1;
                        alu_control = alu_code;
                    end
                    CL_UNARY: {Zlowout, Gra, Rin} = '1;
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_RTYPE, CL_IMM: {Zlowout, Gra, Rin} = '1;
                    CL_LD, CL_ST:     {Zlowout, MARin} = '1;
                    CL_MULDIV:        {Zlowout, LOin} = '1;
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_LD:     {Read, MDRin} = '1;
                    CL_ST:     {Gra, Rout, MDRin} = '1;
                    CL_MULDIV: {Zhighout, HIin} = '1;
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CL_LD:   {MDRout, Gra, Rin} = '1;
                    CL_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
